video_timing_ctrl: RTL
======================

Name: video_timing_ctrl

Overview:
- Generates raster timing that sequences the HDMI/TMDS output path: pixel/line counters, sync strobes and the active-video enable consumed by the TMDS encoders and the pixel source.
- Arbitrates the game logic's access to shared display state (playfield/frame RAM). Game-side updates are granted only during vertical blanking, so the picture never tears mid-frame.
- Sits between the game core and the hdmi_top encode/serialise path, in the pixel clock domain.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels); H_TOTAL = sum = 800
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL = sum = 525
SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
pixclk  in  1  pixel clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
hcount  out  10  current pixel column, 0..H_TOTAL-1
vcount  out  10  current line, 0..V_TOTAL-1
draw_en  out  1  high when hcount<H_ACTIVE and vcount<V_ACTIVE
hsync  out  1  horizontal sync, level SYNC_POL when active
vsync  out  1  vertical sync, level SYNC_POL when active
line_start  out  1  one-cycle pulse when hcount==0
frame_start  out  1  one-cycle pulse when hcount==0 and vcount==0
upd_req  in  1  game logic requests display-state update; level, held until granted
upd_done  in  1  game logic finished update; one-cycle pulse while granted
upd_gnt  out  1  update window open
upd_overrun  out  1  one-cycle pulse: grant revoked at frame start without upd_done

Behaviour:
- Single clock domain (pixclk). Reset is synchronous and active-high. All outputs are registers. Sync, enable and pulse outputs always describe the hcount/vcount values presented in the same cycle.
- Reset state:
  - hcount=H_TOTAL-1, vcount=V_TOTAL-1, draw_en=0, hsync=vsync=~SYNC_POL.
  - line_start=frame_start=0, upd_gnt=0, upd_overrun=0, FSM=IDLE.
  - First edge with rst low presents (0,0) with draw_en=1, line_start=1, frame_start=1.
- Counters:
  - hcount increments every cycle; at H_TOTAL-1 it wraps to 0 and vcount increments.
  - vcount wraps to 0 after V_TOTAL-1 (only at an hcount wrap).
  - No pause or enable input.
- hsync is active for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; default 656..751, on every line including blanking lines.
- vsync is active for whole lines with vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; default 490..491. It asserts and deasserts with hcount==0.
- vblank (internal) = vcount>=V_ACTIVE.
- Update FSM:
  - IDLE:
    - upd_req=1 and vblank and vcount<V_TOTAL-1 -> GRANT (upd_gnt=1 next cycle).
    - upd_req=1 otherwise -> WAIT.
  - WAIT: on the cycle presenting hcount==0, vcount==V_ACTIVE -> GRANT. upd_req dropping while in WAIT -> IDLE, no grant.
  - GRANT:
    - upd_done=1 -> IDLE; upd_gnt falls next cycle.
    - If frame_start is being presented next cycle and upd_done is absent -> IDLE; upd_gnt=0 together with frame_start, upd_overrun pulses for that cycle.
    - upd_done and the wrap on the same edge -> done wins; no overrun.
  - upd_done outside GRANT is ignored. upd_req is ignored in GRANT.
  - Re-request after done within the same vblank is allowed: IDLE rule, grant on the following cycle.
- upd_gnt is never high while draw_en is high.
- rst mid-frame or mid-grant returns immediately (next edge) to the reset state; upd_gnt drops without an upd_overrun pulse.
- Counter widths: parameters must satisfy H_TOTAL<=1024 and V_TOTAL<=1024; no other checking.

Test Plan:
- Reset release: rst high 3 cycles then low -> first post-reset cycle hcount=0, vcount=0, frame_start=1, draw_en=1. 800 cycles later line_start=1, vcount=1.
- Raster sweep: run 2 full frames (840000 cycles) -> frame_start pulses exactly every 420000 cycles. hsync low exactly for hcount 656..751. vsync low exactly on vcount 490..491. draw_en count = 307200 per frame.
- Request during active video: upd_req=1 at vcount=100 -> upd_gnt rises with hcount=0, vcount=480. upd_done pulse at vcount=482 -> upd_gnt low next cycle. No overrun.
- Request in vblank: upd_req at vcount=500 -> upd_gnt=1 next cycle. Request at vcount=524 -> wait, grant at the next frame's vcount=480.
- Overrun: grant at vcount=480, never send upd_done -> upd_gnt falls and upd_overrun=1 on the cycle frame_start=1. Same edge done+wrap -> upd_overrun stays 0.
- Reset mid-grant: assert rst while upd_gnt=1 -> next cycle upd_gnt=0, upd_overrun=0, hcount=799, vcount=524.

Source files
------------

// File: rtl/video_timing_ctrl_if.sv
// -----------------------------------------------------------------------------
// video_timing_ctrl_if
// Bundles the raster timing outputs and the game-side display-update handshake
// of video_timing_ctrl.
//
//   master : the timing controller. It drives hcount/vcount, draw_en,
//            hsync/vsync, line_start/frame_start, upd_gnt and upd_overrun.
//            It receives upd_req and upd_done.
//   slave  : the consumers, meaning the TMDS path, the pixel source and the
//            game core. They drive upd_req and upd_done and observe the rest.
// -----------------------------------------------------------------------------
interface video_timing_ctrl_if;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       draw_en;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;
    logic       upd_req;
    logic       upd_done;
    logic       upd_gnt;
    logic       upd_overrun;

    modport master (
        output hcount, vcount, draw_en, hsync, vsync, line_start, frame_start,
        output upd_gnt, upd_overrun,
        input  upd_req, upd_done
    );

    modport slave (
        input  hcount, vcount, draw_en, hsync, vsync, line_start, frame_start,
        input  upd_gnt, upd_overrun,
        output upd_req, upd_done
    );
endinterface

// File: rtl/video_timing_ctrl.sv
// -----------------------------------------------------------------------------
// video_timing_ctrl
// This block generates raster timing: the pixel and line counters, the sync
// strobes, the active-video enable and the line and frame pulses. It also
// arbitrates game-side updates of the shared display state. A grant is given
// only during vertical blanking, so a frame is never torn.
//
// Ports
//   pixclk : pixel clock. All logic runs on its rising edge.
//   rst    : synchronous, active-high reset.
//   vif    : video_timing_ctrl_if.master
//            outputs: hcount, vcount, draw_en, hsync, vsync, line_start,
//                     frame_start, upd_gnt, upd_overrun (all registered)
//            inputs : upd_req (a level), upd_done (a one-cycle pulse)
//
// Every timing output is decoded from the next counter values and registered
// together with those values. Each output therefore always describes the
// hcount/vcount pair presented in the same cycle.
// H_TOTAL and V_TOTAL must each be <= 1024 to fit the 10-bit counters.
// -----------------------------------------------------------------------------
module video_timing_ctrl #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic                 pixclk,
    input  logic                 rst,
    video_timing_ctrl_if.master  vif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT        = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT        = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST     = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST      = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST     = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST      = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    // A request in IDLE can be granted immediately only up to this line.
    // After it, the grant could not last into the next cycle before the
    // frame-start revoke.
    localparam logic [9:0] V_GRANT_LAST = 10'(V_TOTAL - 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    logic [9:0] hcount_q,      hcount_d;
    logic [9:0] vcount_q,      vcount_d;
    logic       draw_en_q,     draw_en_d;
    logic       hsync_q,       hsync_d;
    logic       vsync_q,       vsync_d;
    logic       line_start_q,  line_start_d;
    logic       frame_start_q, frame_start_d;
    state_t     state_q,       state_d;
    logic       upd_gnt_q,     upd_gnt_d;
    logic       upd_overrun_q, upd_overrun_d;

    logic       vblank;
    logic       window_open;

    // ---------------------------------------------------------------------
    // Counters and the timing decode of the next position
    // ---------------------------------------------------------------------
    always_comb begin
        hcount_d = hcount_q + 10'd1;
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
        end

        draw_en_d     = (hcount_d < H_ACT) && (vcount_d < V_ACT);
        hsync_d       = ((hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = ((vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
        line_start_d  = (hcount_d == '0);
        frame_start_d = (hcount_d == '0) && (vcount_d == '0);
    end

    // The currently presented line is in vertical blanking.
    assign vblank      = (vcount_q >= V_ACT);
    // The next cycle presents the first pixel of vertical blanking.
    assign window_open = (hcount_d == '0) && (vcount_d == V_ACT);

    // ---------------------------------------------------------------------
    // Update arbiter: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge pixclk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // Update arbiter: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // A request that arrives on the last active cycle is granted
                // directly when blanking opens; it does not wait a whole frame.
                if (vif.upd_req) begin
                    if ((vblank && (vcount_q <= V_GRANT_LAST)) || window_open) begin
                        state_d = ST_GRANT;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!vif.upd_req) begin
                    state_d = ST_IDLE;
                end else if (window_open) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // upd_done takes priority over the frame-start revoke when
                // both fall on the same edge.
                if (vif.upd_done || frame_start_d) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Update arbiter: outputs, registered together with the raster
    // ---------------------------------------------------------------------
    always_comb begin
        upd_gnt_d     = (state_d == ST_GRANT);
        upd_overrun_d = (state_q == ST_GRANT) && !vif.upd_done && frame_start_d;
    end

    // ---------------------------------------------------------------------
    // Raster and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge pixclk) begin
        if (rst) begin
            hcount_q      <= H_LAST;
            vcount_q      <= V_LAST;
            draw_en_q     <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            upd_gnt_q     <= 1'b0;
            upd_overrun_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            draw_en_q     <= draw_en_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            upd_gnt_q     <= upd_gnt_d;
            upd_overrun_q <= upd_overrun_d;
        end
    end

    assign vif.hcount      = hcount_q;
    assign vif.vcount      = vcount_q;
    assign vif.draw_en     = draw_en_q;
    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;
    assign vif.upd_gnt     = upd_gnt_q;
    assign vif.upd_overrun = upd_overrun_q;

endmodule
